ifetch: RTL and testbench

- Instruction fetch stage sitting directly upstream of the dual-port instruction ROM (port 0).
- Holds the fetch PC, issues one ROM read per cycle and absorbs the ROM's fixed 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO and delivers {pc, inst} pairs to decode over a valid/ready handshake.
- Supports a branch/jump redirect that squashes all stale fetches.

---
 rtl/ifetch_if.sv | 25 ++
 rtl/ifetch.sv | 113 +++++++++++
 tb/tb_ifetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: ROM port-0 read channel, redirect request and the
// valid/ready delivery channel towards decode.
interface ifetch_if #(
    parameter int SCALE = 10
) ();
    logic             rom_oe;
    logic [SCALE-1:0] rom_addr;
    logic [31:0]      rom_rdata;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;

    modport master (
        output rom_oe, rom_addr, out_valid, out_pc, out_inst,
        input  rom_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  rom_oe, rom_addr, out_valid, out_pc, out_inst,
        output rom_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: one ROM read per cycle, 1-cycle read latency absorbed
// by a 2-entry {pc, inst} FIFO, redirect squashes every stale fetch.
module ifetch #(
    parameter int          SCALE    = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);
    logic [31:0] pc_f_r;
    logic        inflight_r;
    logic [31:0] inflight_pc_r;
    logic [31:0] fifo_pc_r   [2];
    logic [31:0] fifo_inst_r [2];
    logic        head_r;
    logic [1:0]  count_r;

    logic        out_valid_s;
    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic        tail_s;
    logic [2:0]  occ_s;
    logic [31:0] target_s;
    logic [31:0] fetch_pc_s;

    // Handshake and occupancy bookkeeping for the current cycle.
    always_comb begin
        out_valid_s = 1'b0;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        tail_s      = 1'b0;
        occ_s       = 3'd0;
        if (rst) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = (count_r != 2'd0);
        end
        pop_s  = out_valid_s & bus.out_ready;
        // A redirect kills the response of the read issued last cycle.
        push_s = inflight_r & ~bus.redirect;
        // Slot after the last valid entry; a full FIFO never pushes.
        tail_s = head_r ^ count_r[0];
        occ_s  = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    end

    // Fetch address selection and ROM read-enable decision.
    always_comb begin
        issue_s    = 1'b0;
        target_s   = bus.redirect_pc & 32'hFFFF_FFFC;
        fetch_pc_s = pc_f_r;
        if (rst) begin
            issue_s    = 1'b0;
            fetch_pc_s = pc_f_r;
        end else if (bus.redirect) begin
            issue_s    = 1'b1;
            fetch_pc_s = target_s;
        end else begin
            // Only issue when the response is guaranteed a FIFO slot.
            issue_s    = (occ_s <= 3'd1);
            fetch_pc_s = pc_f_r;
        end
    end

    // Fetch PC, in-flight tracking and FIFO state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_r        <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            head_r        <= 1'b0;
            count_r       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_r[i]   <= 32'h0000_0000;
                fifo_inst_r[i] <= 32'h0000_0000;
            end
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_s;
                pc_f_r        <= fetch_pc_s + 32'd4;
            end else begin
                inflight_pc_r <= inflight_pc_r;
                pc_f_r        <= pc_f_r;
            end
            if (bus.redirect) begin
                head_r  <= 1'b0;
                count_r <= 2'd0;
            end else begin
                if (push_s) begin
                    fifo_pc_r[tail_s]   <= inflight_pc_r;
                    fifo_inst_r[tail_s] <= bus.rom_rdata;
                end else begin
                    fifo_pc_r[tail_s]   <= fifo_pc_r[tail_s];
                    fifo_inst_r[tail_s] <= fifo_inst_r[tail_s];
                end
                if (pop_s) begin
                    head_r <= ~head_r;
                end else begin
                    head_r <= head_r;
                end
                count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
            end
        end
    end

    assign bus.rom_oe    = issue_s;
    assign bus.rom_addr  = fetch_pc_s[SCALE+1:2];
    assign bus.out_valid = out_valid_s;
    assign bus.out_pc    = fifo_pc_r[head_r];
    assign bus.out_inst  = fifo_inst_r[head_r];
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: two instances (SCALE=10/RESET_PC=0 and SCALE=4/RESET_PC=0x20)
// each with a ROM model and a queue of expected {pc, inst} deliveries.
module tb_ifetch;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] rom0 [1024];
    logic [31:0] rom1 [16];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    ifetch_if #(.SCALE(10)) bus0 ();
    ifetch_if #(.SCALE(4))  bus1 ();

    ifetch #(.SCALE(10), .RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    ifetch #(.SCALE(4),  .RESET_PC(32'h0000_0020)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    always #5 clk = ~clk;

    // Synchronous ROM models with 1-cycle read latency.
    always @(posedge clk) begin
        if (bus0.rom_oe === 1'b1) bus0.rom_rdata <= rom0[bus0.rom_addr];
        if (bus1.rom_oe === 1'b1) bus1.rom_rdata <= rom1[bus1.rom_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push0(input logic [31:0] pc0, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = pc0 + 32'(i * 4);
            q0.push_back({pc, 32'h0000_0100 + ((pc >> 2) & 32'h0000_03FF)});
        end
    endtask

    task automatic push1(input logic [31:0] pc0, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = pc0 + 32'(i * 4);
            q1.push_back({pc, 32'h0000_0200 + ((pc >> 2) & 32'h0000_000F)});
        end
    endtask

    // Scoreboard: every accepted transfer must match the next expected entry.
    always @(negedge clk) begin
        logic [63:0] e0;
        logic [63:0] e1;
        if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
            e0 = (q0.size() != 0) ? q0.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            chk("dut0 xfer", {bus0.out_pc, bus0.out_inst}, e0);
        end
        if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
            e1 = (q1.size() != 0) ? q1.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            chk("dut1 xfer", {bus1.out_pc, bus1.out_inst}, e1);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom0[i] = 32'h0000_0100 + 32'(i);
        for (int i = 0; i < 16; i++)   rom1[i] = 32'h0000_0200 + 32'(i);
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.redirect = 1'b0; bus0.redirect_pc = 32'h0; bus0.out_ready = 1'b1;
        bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0; bus1.out_ready = 1'b0;
        step();
        mid();
        chk("rst oe", 64'(bus0.rom_oe), 64'd0);
        chk("rst valid", 64'(bus0.out_valid), 64'd0);
        step();

        // Streaming from reset: cycle 0 is the first cycle with rst low.
        rst0 = 1'b0;
        push0(32'h0000_0000, 64);
        mid();
        chk("c0 valid", 64'(bus0.out_valid), 64'd0);
        chk("c0 oe", 64'(bus0.rom_oe), 64'd1);
        chk("c0 addr", 64'(bus0.rom_addr), 64'd0);
        chk("c0 out_pc", 64'(bus0.out_pc), 64'd0);
        chk("c0 out_inst", 64'(bus0.out_inst), 64'd0);
        step();
        mid();
        chk("c1 valid", 64'(bus0.out_valid), 64'd0);
        chk("c1 addr", 64'(bus0.rom_addr), 64'd1);
        step();
        for (int c = 2; c < 10; c++) begin
            mid();
            chk("stream valid", 64'(bus0.out_valid), 64'd1);
            chk("stream oe", 64'(bus0.rom_oe), 64'd1);
            step();
        end

        // Backpressure: head pc 0x20 frozen for 6 cycles, no issue.
        bus0.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            mid();
            chk("bp valid", 64'(bus0.out_valid), 64'd1);
            chk("bp oe", 64'(bus0.rom_oe), 64'd0);
            chk("bp out_pc", 64'(bus0.out_pc), 64'h20);
            chk("bp out_inst", 64'(bus0.out_inst), 64'h108);
            step();
        end
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("release valid", 64'(bus0.out_valid), 64'd1);
            step();
        end

        // Redirect with an entry buffered and a read in flight.
        bus0.out_ready = 1'b0;
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0040;
        mid();
        chk("redir oe", 64'(bus0.rom_oe), 64'd1);
        chk("redir addr", 64'(bus0.rom_addr), 64'h10);
        step();
        bus0.redirect = 1'b0;
        bus0.out_ready = 1'b1;
        q0.delete();
        push0(32'h0000_0040, 32);
        mid();
        chk("redir+1 valid", 64'(bus0.out_valid), 64'd0);
        step();
        mid();
        chk("redir+2 valid", 64'(bus0.out_valid), 64'd1);
        chk("redir+2 out_pc", 64'(bus0.out_pc), 64'h40);
        chk("redir+2 out_inst", 64'(bus0.out_inst), 64'h110);
        step();
        step();
        step();

        // Redirect coincident with an accepted head (pc 0x4C), misaligned target.
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0043;
        mid();
        chk("redirpop head", 64'(bus0.out_pc), 64'h4C);
        chk("redirpop addr", 64'(bus0.rom_addr), 64'h10);
        step();
        bus0.redirect = 1'b0;
        q0.delete();
        push0(32'h0000_0040, 32);
        mid();
        chk("redirpop+1 valid", 64'(bus0.out_valid), 64'd0);
        step();
        mid();
        chk("redirpop+2 out_pc", 64'(bus0.out_pc), 64'h40);
        step();
        for (int c = 0; c < 4; c++) step();
        bus0.out_ready = 1'b0;

        // Address wrap on the SCALE=4 instance, fetch from 0x38.
        rst1 = 1'b0;
        bus1.out_ready = 1'b1;
        bus1.redirect = 1'b1;
        bus1.redirect_pc = 32'h0000_0038;
        push1(32'h0000_0038, 16);
        mid();
        chk("wrap addr0", 64'(bus1.rom_addr), 64'd14);
        step();
        bus1.redirect = 1'b0;
        mid();
        chk("wrap addr1", 64'(bus1.rom_addr), 64'd15);
        step();
        mid();
        chk("wrap addr2", 64'(bus1.rom_addr), 64'd0);
        chk("wrap pc0", 64'(bus1.out_pc), 64'h38);
        step();
        mid();
        chk("wrap addr3", 64'(bus1.rom_addr), 64'd1);
        chk("wrap pc1", 64'(bus1.out_pc), 64'h3C);
        step();
        mid();
        chk("wrap pc2", 64'(bus1.out_pc), 64'h40);
        chk("wrap inst2", 64'(bus1.out_inst), 64'h200);
        step();
        mid();
        chk("wrap pc3", 64'(bus1.out_pc), 64'h44);
        step();

        // Mid-run reset with an entry buffered and a read in flight.
        rst1 = 1'b1;
        bus1.out_ready = 1'b0;
        mid();
        chk("mrst valid", 64'(bus1.out_valid), 64'd0);
        chk("mrst oe", 64'(bus1.rom_oe), 64'd0);
        step();
        rst1 = 1'b0;
        bus1.out_ready = 1'b1;
        q1.delete();
        push1(32'h0000_0020, 16);
        mid();
        chk("mrst+1 out_pc", 64'(bus1.out_pc), 64'd0);
        chk("mrst+1 out_inst", 64'(bus1.out_inst), 64'd0);
        chk("mrst+1 valid", 64'(bus1.out_valid), 64'd0);
        chk("mrst+1 oe", 64'(bus1.rom_oe), 64'd1);
        chk("mrst+1 addr", 64'(bus1.rom_addr), 64'd8);
        step();
        mid();
        chk("mrst+2 valid", 64'(bus1.out_valid), 64'd0);
        step();
        mid();
        chk("mrst+3 valid", 64'(bus1.out_valid), 64'd1);
        chk("mrst+3 out_pc", 64'(bus1.out_pc), 64'h20);
        chk("mrst+3 out_inst", 64'(bus1.out_inst), 64'h208);
        step();
        for (int c = 0; c < 4; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
